// File: rtl/ext_pkg.sv
// Shared definitions for the ext_pipe immediate/load-data extender:
// op encodings and the skid-buffer FSM state type.
package ext_pkg;

  localparam int EXT_OP_W = 3;

  localparam logic [EXT_OP_W-1:0] EXT_ZERO  = 3'd0;
  localparam logic [EXT_OP_W-1:0] EXT_SIGN  = 3'd1;
  localparam logic [EXT_OP_W-1:0] EXT_UPPER = 3'd2;
  localparam logic [EXT_OP_W-1:0] EXT_LB    = 3'd3;
  localparam logic [EXT_OP_W-1:0] EXT_LBU   = 3'd4;
  localparam logic [EXT_OP_W-1:0] EXT_LH    = 3'd5;
  localparam logic [EXT_OP_W-1:0] EXT_LHU   = 3'd6;
  localparam logic [EXT_OP_W-1:0] EXT_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } ext_state_e;

endpackage

// File: rtl/ext_skid_buf.sv
// Two-entry registered skid buffer with valid/ready on both sides.
// The output register holds the head entry; the skid register catches one
// extra entry so that back-pressure never drops data. in_ready depends only
// on registered state (and reset), never on out_ready.
module ext_skid_buf
  import ext_pkg::*;
#(
  parameter int PAY_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PAY_W-1:0] in_pay,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PAY_W-1:0] out_pay
);

  ext_state_e       r_state;
  logic             r_vld;
  logic [PAY_W-1:0] r_out;
  logic [PAY_W-1:0] r_skid;
  logic             w_accept;
  logic             w_drain;

  // Full only in TWO; held low while reset is asserted.
  assign in_ready  = (r_state != ST_TWO) && reset;
  assign out_valid = r_vld;
  assign out_pay   = r_out;
  assign w_accept  = in_valid && in_ready;
  assign w_drain   = r_vld && out_ready;

  // Occupancy FSM with registered output valid; entries leave in arrival order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_vld   <= 1'b0;
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_out   <= in_pay;
            r_vld   <= 1'b1;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && !w_drain) begin
            r_skid  <= in_pay;
            r_state <= ST_TWO;
          end else if (w_accept && w_drain) begin
            r_out   <= in_pay;
          end else if (w_drain) begin
            r_vld   <= 1'b0;
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drain) begin
            r_out   <= r_skid;
            r_state <= ST_ONE;
          end
        end
        default: begin
          r_vld   <= 1'b0;
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ext_pipe.sv
// Registered immediate / load-data extender.
// Combinational extension (imm zero/sign/upper, lb/lbu/lh/lhu, reserved ->
// all ones) feeds an ext_skid_buf that provides the output register and
// back-pressure handling.
// Optional macro EXT_ERR_EN adds a registered out_err flag for the reserved
// op and misaligned half-word loads.
module ext_pipe
  import ext_pkg::*;
#(
  parameter  int IN_W   = 16,
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [EXT_OP_W-1:0] in_op,
  input  logic [IN_W-1:0]     in_imm,
  input  logic [DATA_W-1:0]   in_word,
  input  logic [OFF_W-1:0]    in_off,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data
`ifdef EXT_ERR_EN
  ,
  output logic                out_err
`endif
);

`ifdef EXT_ERR_EN
  localparam int PAY_W = DATA_W + 1;
`else
  localparam int PAY_W = DATA_W;
`endif

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_data;
  logic [PAY_W-1:0]  w_pay_in;
  logic [PAY_W-1:0]  w_pay_out;

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
    return {{(DATA_W-8){v[7]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext8(input logic [7:0] v);
    return {{(DATA_W-8){1'b0}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
    return {{(DATA_W-16){1'b0}}, v};
  endfunction

  // Little-endian lane select; the half index ignores off[0], so a
  // misaligned half reads the aligned half containing the addressed byte.
  assign w_byte = 8'(in_word >> {in_off, 3'b000});
  assign w_half = 16'(in_word >> {(in_off >> 1), 4'b0000});

  // Mode decode: pure bit selection and replication.
  always_comb begin
    w_data = '1;
    case (in_op)
      EXT_ZERO:  w_data = {{(DATA_W-IN_W){1'b0}}, in_imm};
      EXT_SIGN:  w_data = {{(DATA_W-IN_W){in_imm[IN_W-1]}}, in_imm};
      EXT_UPPER: w_data = {in_imm, {(DATA_W-IN_W){1'b0}}};
      EXT_LB:    w_data = sext8(w_byte);
      EXT_LBU:   w_data = zext8(w_byte);
      EXT_LH:    w_data = sext16(w_half);
      EXT_LHU:   w_data = zext16(w_half);
      EXT_RSVD:  w_data = '1;
      default:   w_data = '1;
    endcase
  end

`ifdef EXT_ERR_EN
  logic w_err;

  // Flag the reserved op and any half load that is not half-aligned.
  always_comb begin
    w_err = 1'b0;
    if (in_op == EXT_RSVD) begin
      w_err = 1'b1;
    end else if ((in_op == EXT_LH) || (in_op == EXT_LHU)) begin
      w_err = in_off[0] || ((DATA_W == 16) && (in_off != '0));
    end
  end

  assign w_pay_in            = {w_err, w_data};
  assign {out_err, out_data} = w_pay_out;
`else
  assign w_pay_in = w_data;
  assign out_data = w_pay_out;
`endif

  ext_skid_buf #(
    .PAY_W (PAY_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pay    (w_pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pay   (w_pay_out)
  );

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe (IN_W=16, DATA_W=32).
// Define EXT_ERR_EN on both RTL and bench to exercise out_err.
module tb_ext_pipe;

  localparam int IN_W   = 16;
  localparam int DATA_W = 32;
  localparam int OFF_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [IN_W-1:0]   in_imm;
  logic [DATA_W-1:0] in_word;
  logic [OFF_W-1:0]  in_off;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef EXT_ERR_EN
  logic              out_err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ext_pipe #(.IN_W(IN_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_imm    (in_imm),
    .in_word   (in_word),
    .in_off    (in_off),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef EXT_ERR_EN
    ,
    .out_err   (out_err)
`endif
  );

  // Reference: lanes via division/modulo, sign extension by adding the fill.
  function automatic logic [31:0] model_data(input logic [2:0] op, input logic [15:0] imm,
                                             input logic [31:0] word, input logic [1:0] off);
    longint unsigned w, i, b, h;
    w = 64'(word);
    i = 64'(imm);
    b = (w / (64'd1 << (8 * int'(off)))) % 256;
    h = (w / (64'd1 << (16 * (int'(off) / 2)))) % 65536;
    case (op)
      3'd0:    return 32'(i);
      3'd1:    return 32'((i >= 32768) ? i + 64'hFFFF0000 : i);
      3'd2:    return 32'(i * 65536);
      3'd3:    return 32'((b >= 128) ? b + 64'hFFFFFF00 : b);
      3'd4:    return 32'(b);
      3'd5:    return 32'((h >= 32768) ? h + 64'hFFFF0000 : h);
      3'd6:    return 32'(h);
      default: return 32'hFFFFFFFF;
    endcase
  endfunction

`ifdef EXT_ERR_EN
  function automatic logic model_err(input logic [2:0] op, input logic [1:0] off);
    return (op == 3'd7) || (((op == 3'd5) || (op == 3'd6)) && ((int'(off) % 2) == 1));
  endfunction
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [15:0] imm,
                       input logic [31:0] word, input logic [1:0] off);
    in_op    = op;
    in_imm   = imm;
    in_word  = word;
    in_off   = off;
    in_valid = 1'b1;
  endtask

  task automatic flush();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
  endtask

  // One transaction with out_ready=1, result expected one edge later.
  task automatic send_check(input string name, input logic [2:0] op, input logic [15:0] imm,
                            input logic [31:0] word, input logic [1:0] off, input logic [31:0] exp);
    out_ready = 1'b1;
    drive(op, imm, word, off);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== exp) begin
      n_fail++;
      $display("FAIL %s: got vld=%b data=%h want vld=1 data=%h", name, out_valid, out_data, exp);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(3'd0, 16'h0, 32'h0, 2'd0);
    in_valid  = 1'b0;
    step();
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got vld=%b data=%h rdy=%b want 0 0 0", out_valid, out_data, in_ready);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    step();
  endtask

  task automatic test_imm();
    send_check("imm_zero",  3'd0, 16'h8001, 32'h0, 2'd0, 32'h00008001);
    send_check("imm_sign",  3'd1, 16'h8001, 32'h0, 2'd0, 32'hFFFF8001);
    send_check("imm_upper", 3'd2, 16'h8001, 32'h0, 2'd0, 32'h80010000);
    send_check("imm_sign_pos", 3'd1, 16'h7FFF, 32'h0, 2'd0, 32'h00007FFF);
    step();
  endtask

  task automatic test_loads();
    send_check("lb_off3",  3'd3, 16'h0, 32'h80FF7F01, 2'd3, 32'hFFFFFF80);
    send_check("lbu_off1", 3'd4, 16'h0, 32'h80FF7F01, 2'd1, 32'h0000007F);
    send_check("lh_off2",  3'd5, 16'h0, 32'h80FF7F01, 2'd2, 32'hFFFF80FF);
    send_check("lhu_off0", 3'd6, 16'h0, 32'h80FF7F01, 2'd0, 32'h00007F01);
    send_check("lb_off2",  3'd3, 16'h0, 32'h80FF7F01, 2'd2, 32'hFFFFFFFF);
    send_check("rsvd",     3'd7, 16'h1234, 32'h0, 2'd0, 32'hFFFFFFFF);
    step();
  endtask

  task automatic test_backpressure();
    flush();
    out_ready = 1'b0;
    drive(3'd0, 16'h1111, 32'h0, 2'd0);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_acceptA: got rdy=%b want 1", in_ready); end
    step();
    drive(3'd0, 16'h2222, 32'h0, 2'd0);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_acceptB: got rdy=%b want 1", in_ready); end
    step();
    drive(3'd0, 16'h3333, 32'h0, 2'd0);
    n_cmp++;
    if (in_ready !== 1'b0 || out_data !== 32'h00001111) begin
      n_fail++;
      $display("FAIL bp_full: got rdy=%b data=%h want 0 00001111", in_ready, out_data);
    end
    step();
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h00001111) begin
      n_fail++;
      $display("FAIL bp_stable: got rdy=%b vld=%b data=%h want 0 1 00001111", in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h00002222 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_outB: got vld=%b data=%h rdy=%b want 1 00002222 1", out_valid, out_data, in_ready);
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h00003333) begin
      n_fail++;
      $display("FAIL bp_outC: got vld=%b data=%h want 1 00003333", out_valid, out_data);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got vld=%b want 0", out_valid); end
  endtask

  task automatic test_simultaneous();
    flush();
    out_ready = 1'b0;
    drive(3'd1, 16'hABCD, 32'h0, 2'd0);
    step();
    drive(3'd2, 16'h5A5A, 32'h0, 2'd0);
    out_ready = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_data !== 32'hFFFFABCD) begin
      n_fail++;
      $display("FAIL simul_pre: got rdy=%b data=%h want 1 ffffabcd", in_ready, out_data);
    end
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'h5A5A0000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_post: got vld=%b data=%h rdy=%b want 1 5a5a0000 1", out_valid, out_data, in_ready);
    end
    flush();
  endtask

  task automatic test_reset_mid();
    flush();
    out_ready = 1'b0;
    drive(3'd0, 16'hBEEF, 32'h0, 2'd0);
    step();
    drive(3'd0, 16'hCAFE, 32'h0, 2'd0);
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_full: got rdy=%b want 0", in_ready); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_async: got vld=%b data=%h rdy=%b want 0 0 0", out_valid, out_data, in_ready);
    end
    step();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_release: got rdy=%b want 1", in_ready); end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_stale: got vld=%b data=%h want 0 0", out_valid, out_data);
    end
  endtask

`ifdef EXT_ERR_EN
  task automatic test_err();
    logic [2:0]  ops[3]  = '{3'd7, 3'd5, 3'd3};
    logic [1:0]  offs[3] = '{2'd0, 2'd1, 2'd1};
    logic [31:0] dat[3]  = '{32'hFFFFFFFF, 32'h00007F01, 32'h0000007F};
    logic        errs[3] = '{1'b1, 1'b1, 1'b0};
    flush();
    for (int k = 0; k < 3; k++) begin
      out_ready = 1'b1;
      drive(ops[k], 16'h0, 32'h80FF7F01, offs[k]);
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== dat[k] || out_err !== errs[k]) begin
        n_fail++;
        $display("FAIL err_%0d: got vld=%b data=%h err=%b want 1 %h %b", k, out_valid, out_data, out_err, dat[k], errs[k]);
      end
    end
    flush();
  endtask
`endif

  task automatic test_random();
    logic [31:0] q[$];
`ifdef EXT_ERR_EN
    logic        qe[$];
    logic        exp_e;
`endif
    logic [2:0]  op;
    logic [15:0] imm;
    logic [31:0] word;
    logic [1:0]  off;
    logic [31:0] exp_d;
    bit          acc;
    bit          drn;
    int          t;
    flush();
    op = 3'd0; imm = 16'h0; word = 32'h0; off = 2'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!in_valid && ($urandom_range(0, 3) != 0)) begin
        op   = 3'($urandom_range(0, 7));
        imm  = 16'($urandom);
        word = $urandom;
        off  = 2'($urandom_range(0, 3));
        drive(op, imm, word, off);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      n_cmp++;
      if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0)) begin
        n_fail++;
        $display("FAIL rand_occ cyc%0d: got rdy=%b vld=%b want occupancy %0d", cyc, in_ready, out_valid, q.size());
      end
      acc = in_valid && (q.size() < 2);
      drn = out_ready && (q.size() > 0);
      if (drn) begin
        n_cmp++;
        if (out_data !== q[0]) begin
          n_fail++;
          $display("FAIL rand_data cyc%0d: got %h want %h", cyc, out_data, q[0]);
        end
`ifdef EXT_ERR_EN
        n_cmp++;
        if (out_err !== qe[0]) begin
          n_fail++;
          $display("FAIL rand_err cyc%0d: got %b want %b", cyc, out_err, qe[0]);
        end
`endif
      end
      exp_d = model_data(op, imm, word, off);
`ifdef EXT_ERR_EN
      exp_e = model_err(op, off);
`endif
      step();
      if (drn) begin
        void'(q.pop_front());
`ifdef EXT_ERR_EN
        void'(qe.pop_front());
`endif
      end
      if (acc) begin
        q.push_back(exp_d);
`ifdef EXT_ERR_EN
        qe.push_back(exp_e);
`endif
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (q.size() > 0 && t < 10) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== q[0]) begin
        n_fail++;
        $display("FAIL rand_drain: got vld=%b data=%h want 1 %h", out_valid, out_data, q[0]);
      end
      step();
      void'(q.pop_front());
`ifdef EXT_ERR_EN
      void'(qe.pop_front());
`endif
      t++;
    end
    n_cmp++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_final: got vld=%b left=%0d want 0 0", out_valid, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_loads();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
`ifdef EXT_ERR_EN
    test_err();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
